// File: rtl/pzcorebus_pkg.sv
// rtl/pzcorebus_pkg.sv - shared types and helpers for the pzcorebus data path
//
// Contents:
//   pzcorebus_packer_state_e   packer FSM states (IDLE, ACCUM)
//   pzcorebus_packer_ratio()   lane count of a slave-to-master upsizing path
package pzcorebus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pzcorebus_packer_state_e;

    function automatic int pzcorebus_packer_ratio(input int slave_width, input int master_width);
        return master_width / slave_width;
    endfunction

endpackage

// File: rtl/pzcorebus_data_packer.sv
// rtl/pzcorebus_data_packer.sv - packs narrow write-data beats into master-width words
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_clear              synchronous flush of partial and output words
//   i_bypass, i_offset   burst mode and start lane, taken from the first beat only
//   i_valid/o_ready      narrow beat handshake; i_data, i_byteen, i_last beat payload
//   o_valid/i_ready      wide word handshake; o_data, o_byteen, o_last word payload
//   o_busy               burst in progress or output word pending
module pzcorebus_data_packer
    import pzcorebus_pkg::*;
#(
    parameter int SLAVE_DATA_WIDTH  = 32,
    parameter int MASTER_DATA_WIDTH = 128,
    parameter int RATIO             = pzcorebus_packer_ratio(SLAVE_DATA_WIDTH, MASTER_DATA_WIDTH),
    parameter int OFFSET_WIDTH      = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_clear,
    input  logic                           i_bypass,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [OFFSET_WIDTH-1:0]        i_offset,
    input  logic [SLAVE_DATA_WIDTH-1:0]    i_data,
    input  logic [SLAVE_DATA_WIDTH/8-1:0]  i_byteen,
    input  logic                           i_last,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [MASTER_DATA_WIDTH-1:0]   o_data,
    output logic [MASTER_DATA_WIDTH/8-1:0] o_byteen,
    output logic                           o_last,
    output logic                           o_busy
);

    localparam int SLAVE_BYTES  = SLAVE_DATA_WIDTH / 8;
    localparam int MASTER_BYTES = MASTER_DATA_WIDTH / 8;
    localparam logic [OFFSET_WIDTH-1:0] LAST_LANE = OFFSET_WIDTH'(RATIO - 1);

    if (RATIO < 1 || RATIO > 16 || (RATIO & (RATIO - 1)) != 0) begin : g_ratio_check
        $fatal(1, "pzcorebus_data_packer: RATIO %0d must be a power of two in 1..16", RATIO);
    end

    pzcorebus_packer_state_e     state_q, state_d;
    logic [OFFSET_WIDTH-1:0]     ptr_q, ptr_d;
    logic                        mode_q, mode_d;
    logic [MASTER_DATA_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [MASTER_BYTES-1:0]     acc_be_q, acc_be_d;
    logic [MASTER_DATA_WIDTH-1:0] merged_data;
    logic [MASTER_BYTES-1:0]     merged_be;
    logic [RATIO-1:0]            lane_hit;
    logic [OFFSET_WIDTH-1:0]     beat_ptr;
    logic                        beat_mode;
    logic                        beat_accept;
    logic                        word_complete;

    // The output register can take a new word whenever it is empty or being
    // popped in this same cycle, so every beat (completing or not) uses this.
    assign o_ready     = !o_valid || i_ready;
    assign beat_accept = i_valid && o_ready;
    assign o_busy      = (state_q == ACCUM) || o_valid;

    // Lane and mode seen by the current beat: a first beat takes them from the
    // inputs, later beats from the registers. Bypass always uses lane 0, and a
    // single-lane packer has no offset or mode to choose.
    always_comb begin
        beat_ptr  = ptr_q;
        beat_mode = mode_q;
        if (state_q == IDLE) begin
            beat_mode = (RATIO == 1) ? 1'b0 : i_bypass;
            beat_ptr  = (RATIO == 1 || i_bypass) ? '0 : i_offset;
        end
    end

    assign word_complete = i_last || (beat_ptr == LAST_LANE) || beat_mode;

    // Accumulator contents with the current beat dropped into its lane.
    // Lanes never written stay at zero data / zero byte enables.
    for (genvar lane = 0; lane < RATIO; lane++) begin : g_lane
        assign lane_hit[lane] = (beat_ptr == OFFSET_WIDTH'(lane));
        assign merged_data[lane*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] =
            lane_hit[lane] ? i_data : acc_data_q[lane*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH];
        assign merged_be[lane*SLAVE_BYTES +: SLAVE_BYTES] =
            lane_hit[lane] ? i_byteen : acc_be_q[lane*SLAVE_BYTES +: SLAVE_BYTES];
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mode_d     = mode_q;
        acc_data_d = acc_data_q;
        acc_be_d   = acc_be_q;
        if (i_clear) begin
            state_d    = IDLE;
            ptr_d      = '0;
            mode_d     = 1'b0;
            acc_data_d = '0;
            acc_be_d   = '0;
        end else if (beat_accept) begin
            mode_d = beat_mode;
            if (word_complete) begin
                // Merged word leaves for the output register; a burst that
                // continues wraps to lane 0 without re-reading i_offset.
                state_d    = i_last ? IDLE : ACCUM;
                ptr_d      = '0;
                acc_data_d = '0;
                acc_be_d   = '0;
            end else begin
                state_d    = ACCUM;
                ptr_d      = beat_ptr + 1'b1;
                acc_data_d = merged_data;
                acc_be_d   = merged_be;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            mode_q     <= 1'b0;
            acc_data_q <= '0;
            acc_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mode_q     <= mode_d;
            acc_data_q <= acc_data_d;
            acc_be_q   <= acc_be_d;
        end
    end

    // Output register: a completing beat reloads it even while the previous
    // word is popped in the same cycle, keeping o_valid high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_byteen <= '0;
            o_last   <= 1'b0;
        end else if (i_clear) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_byteen <= '0;
            o_last   <= 1'b0;
        end else if (beat_accept && word_complete) begin
            o_valid  <= 1'b1;
            o_data   <= merged_data;
            o_byteen <= merged_be;
            o_last   <= i_last;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pzcorebus_data_packer.sv
// tb/tb_pzcorebus_data_packer.sv - scoreboard bench for pzcorebus_data_packer (32 to 128 bits)
module tb_pzcorebus_data_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_clear;
    logic         i_bypass;
    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_offset;
    logic [31:0]  i_data;
    logic [3:0]   i_byteen;
    logic         i_last;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
    logic [15:0]  o_byteen;
    logic         o_last;
    logic         o_busy;

    always #5 clk = ~clk;

    pzcorebus_data_packer #(
        .SLAVE_DATA_WIDTH  (32),
        .MASTER_DATA_WIDTH (128)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clear  (i_clear),
        .i_bypass (i_bypass),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_offset (i_offset),
        .i_data   (i_data),
        .i_byteen (i_byteen),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_byteen (o_byteen),
        .o_last   (o_last),
        .o_busy   (o_busy)
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  be;
        logic         last;
    } word_t;

    word_t exp_q[$];
    word_t mon_w;
    int    vectors     = 0;
    int    miscompares = 0;

    localparam logic [127:0] STALL_WORD = 128'h04040404_03030303_02020202_01010101;

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_be(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [127:0] d, input logic [15:0] be, input logic last);
        word_t w;
        w.data = d;
        w.be   = be;
        w.last = last;
        exp_q.push_back(w);
    endtask

    // Monitor: a word is taken at the next rising edge when o_valid && i_ready
    // hold at the falling edge before it.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got data %h byteen %h last %b, required no word",
                         o_data, o_byteen, o_last);
            end else begin
                mon_w = exp_q.pop_front();
                check_vec("word_data", o_data, mon_w.data);
                check_be("word_byteen", o_byteen, mon_w.be);
                check_bit("word_last", o_last, mon_w.last);
            end
        end
    end

    // Called one time unit after a rising edge; returns one time unit after
    // the edge that accepted the beat.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] be, input logic [1:0] off,
                             input logic byp, input logic last);
        logic rdy;
        int   waited;
        waited   = 0;
        i_valid  = 1'b1;
        i_data   = d;
        i_byteen = be;
        i_offset = off;
        i_bypass = byp;
        i_last   = last;
        do begin
            #8 rdy = o_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 200);
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_accept_timeout: o_ready low for %0d cycles, required accept", waited);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_bit("drain_complete", (exp_q.size() == 0) && !o_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        i_clear  = 1'b0;
        i_bypass = 1'b0;
        i_valid  = 1'b0;
        i_offset = 2'd0;
        i_data   = 32'h0;
        i_byteen = 4'h0;
        i_last   = 1'b0;
        i_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_valid", o_valid, 1'b0);
        check_vec("rst_data", o_data, 128'h0);
        check_be("rst_byteen", o_byteen, 16'h0);
        check_bit("rst_last", o_last, 1'b0);
        check_bit("rst_busy", o_busy, 1'b0);
        check_bit("rst_ready", o_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full word from lane 0, one-cycle latency
        expect_word(128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1);
        send_beat(32'h11111111, 4'hF, 2'd0, 1'b0, 1'b0);
        send_beat(32'h22222222, 4'hF, 2'd0, 1'b0, 1'b0);
        send_beat(32'h33333333, 4'hF, 2'd0, 1'b0, 1'b0);
        check_bit("t1_valid_before_last", o_valid, 1'b0);
        check_bit("t1_busy_mid", o_busy, 1'b1);
        send_beat(32'h44444444, 4'hF, 2'd0, 1'b0, 1'b1);
        check_bit("t1_valid_latency", o_valid, 1'b1);
        drain();

        // Offset 2, burst wraps into a second word
        expect_word(128'hB1B1B1B1_A0A0A0A0_00000000_00000000, 16'hFF00, 1'b0);
        expect_word(128'h00000000_00000000_00000000_C2C2C2C2, 16'h000F, 1'b1);
        send_beat(32'hA0A0A0A0, 4'hF, 2'd2, 1'b0, 1'b0);
        send_beat(32'hB1B1B1B1, 4'hF, 2'd2, 1'b0, 1'b0);
        send_beat(32'hC2C2C2C2, 4'hF, 2'd2, 1'b0, 1'b1);
        drain();

        // Single partial beat on lane 1
        expect_word(128'h00000000_00000000_0000BEEF_00000000, 16'h0030, 1'b1);
        send_beat(32'h0000BEEF, 4'h3, 2'd1, 1'b0, 1'b1);
        drain();

        // Bypass taken from the first beat only; later beats say otherwise
        expect_word(128'h00000000_00000000_00000000_5A5A0001, 16'h000F, 1'b0);
        expect_word(128'h00000000_00000000_00000000_5A5A0002, 16'h000F, 1'b0);
        expect_word(128'h00000000_00000000_00000000_5A5A0003, 16'h000F, 1'b1);
        send_beat(32'h5A5A0001, 4'hF, 2'd3, 1'b1, 1'b0);
        send_beat(32'h5A5A0002, 4'hF, 2'd1, 1'b0, 1'b0);
        send_beat(32'h5A5A0003, 4'hF, 2'd2, 1'b0, 1'b1);
        drain();

        // Zero-byteen beat still occupies its lane
        expect_word(128'h00000000_00000000_9ABCDEF0_12345678, 16'h00C0, 1'b1);
        send_beat(32'h12345678, 4'h0, 2'd0, 1'b0, 1'b0);
        send_beat(32'h9ABCDEF0, 4'hC, 2'd0, 1'b0, 1'b1);
        drain();

        // Output stall with a beat stream waiting behind it
        i_ready = 1'b0;
        expect_word(STALL_WORD, 16'hFFFF, 1'b1);
        send_beat(32'h01010101, 4'hF, 2'd0, 1'b0, 1'b0);
        send_beat(32'h02020202, 4'hF, 2'd0, 1'b0, 1'b0);
        send_beat(32'h03030303, 4'hF, 2'd0, 1'b0, 1'b0);
        send_beat(32'h04040404, 4'hF, 2'd0, 1'b0, 1'b1);
        expect_word(128'h80000004_80000003_80000002_80000001, 16'hFFFF, 1'b0);
        expect_word(128'h80000008_80000007_80000006_80000005, 16'hFFFF, 1'b1);
        fork
            begin
                for (int n = 1; n <= 8; n++)
                    send_beat(32'h80000000 + 32'(n), 4'hF, 2'd0, 1'b0, n == 8);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check_bit("stall_ready", o_ready, 1'b0);
                    check_bit("stall_valid", o_valid, 1'b1);
                    check_vec("stall_data", o_data, STALL_WORD);
                end
                @(posedge clk);
                #2;
                i_ready = 1'b1;
            end
        join
        drain();

        // Clear mid-burst; the beat offered alongside the clear is discarded
        send_beat(32'hCAFE0001, 4'hF, 2'd0, 1'b0, 1'b0);
        send_beat(32'hCAFE0002, 4'hF, 2'd0, 1'b0, 1'b0);
        check_bit("clr_busy_before", o_busy, 1'b1);
        i_clear  = 1'b1;
        i_valid  = 1'b1;
        i_data   = 32'hCAFE0003;
        i_byteen = 4'hF;
        i_last   = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        check_bit("clr_valid", o_valid, 1'b0);
        check_bit("clr_busy", o_busy, 1'b0);
        expect_word(128'h00000000_00000000_00000000_CAFE0004, 16'h000F, 1'b1);
        send_beat(32'hCAFE0004, 4'hF, 2'd0, 1'b0, 1'b1);
        drain();

        // Reset mid-burst; next beat is a first beat again
        send_beat(32'hBBBB0001, 4'hF, 2'd0, 1'b0, 1'b0);
        send_beat(32'hBBBB0002, 4'hF, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_bit("mrst_busy", o_busy, 1'b0);
        check_bit("mrst_valid", o_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_word(128'h00000000_77777777_00000000_00000000, 16'h0F00, 1'b1);
        send_beat(32'h77777777, 4'hF, 2'd2, 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pzcorebus_data_packer.md
# pzcorebus_data_packer

Parametrised write-data packer for the corebus upsizing path: it packs narrow slave-side data beats into master-width words. Each beat lands on a lane, and a burst may start on any lane. Unfilled lanes are flushed with zero byte enables when a burst ends, and wrap-around is handled inside long bursts. A runtime bypass mode forwards beats on lane 0 one-for-one. It sits between the command/data aligner and the master FIFO, replacing a fixed-ratio conversion stage.

## Interface
- SLAVE_DATA_WIDTH, 32, narrow beat width in bits; multiple of 8.
- MASTER_DATA_WIDTH, 128, wide word width in bits; power-of-two multiple of SLAVE_DATA_WIDTH.
- RATIO, MASTER_DATA_WIDTH/SLAVE_DATA_WIDTH, lane count; legal range 1..16.
- OFFSET_WIDTH, max(1,$clog2(RATIO)), lane index width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous assertion, active-low.
- i_clear  in  1  synchronous flush: drops the partial word and the output word, and returns to IDLE.
- i_bypass  in  1  bypass mode; sampled only on the first beat of a burst.
- i_valid  in  1  narrow beat valid.
- o_ready  out  1  narrow beat ready.
- i_offset  in  OFFSET_WIDTH  start lane; sampled only on the first beat of a burst.
- i_data  in  SLAVE_DATA_WIDTH  beat data.
- i_byteen  in  SLAVE_DATA_WIDTH/8  beat byte enables.
- i_last  in  1  last beat of the burst.
- o_valid  out  1  wide word valid.
- i_ready  in  1  wide word ready.
- o_data  out  MASTER_DATA_WIDTH  wide data.
- o_byteen  out  MASTER_DATA_WIDTH/8  wide byte enables.
- o_last  out  1  word holds the last beat of the burst.
- o_busy  out  1  high in ACCUM or while o_valid is high.

## Operation
- States:
  - IDLE: the next beat is the first beat of a burst.
  - ACCUM: mid-burst, with a partial word held in the accumulator.
- Beat acceptance: a beat is accepted when i_valid && o_ready.
- First-beat capture: the first beat captures lane pointer ptr = i_offset and mode = i_bypass.
  - In bypass, ptr is forced to 0.
- Lane write: an accepted beat writes lane ptr of the accumulator with its data and byteen.
- Word complete: a word completes when the beat has i_last, or ptr == RATIO-1, or mode is bypass.
  - On complete, the accumulator's merged contents move to the output register, and the accumulator lanes clear to data 0 / byteen 0.
  - o_last takes the i_last of the completing beat.
  - Next state is IDLE if i_last, else ACCUM with ptr = 0 (wrap). The offset is not re-sampled on wrap.
- Not complete: ptr increments and the state is ACCUM.
- Unwritten lanes always present data 0 and byteen 0.
  - A beat with all-zero byteen still occupies its lane.
- RATIO == 1: every beat completes a word; i_offset and i_bypass are ignored.
- Beats with i_offset + beats > RATIO wrap into the following word; this is legal.

## Timing
- Reset values:
  - o_valid 0, o_data 0, o_byteen 0, o_last 0, o_busy 0.
  - State IDLE, ptr 0, accumulator 0.
- o_ready = !o_valid || i_ready. This is combinational from i_ready and holds for all beats, not only completing ones.
- Latency: a beat completing a word at edge t gives o_valid at t+1. Sustained throughput is one narrow beat per cycle.
- Output handshake rules:
  - o_valid stays high and all outputs stay stable until i_ready.
  - Output pop and a new completing beat in the same cycle: the new word loads and o_valid stays high.
- i_clear has priority over every handshake in that cycle.
  - All state and outputs return to their reset values at the next edge.
  - o_ready is still computed normally, but accepted beats are discarded.
- Reset mid-burst discards the partial word. The next beat is treated as a first beat.

## Structure
- pzcorebus_pkg additions:
  - Function pzcorebus_packer_ratio(slave_width, master_width).
  - Enum pzcorebus_packer_state_e {IDLE, ACCUM}.
- Elaboration check: $fatal if RATIO is not a power of two or exceeds 16.
- No sub-module. Accumulator, ptr and output register are flat; the lane write uses a generate loop over RATIO.

## Test plan
- 32→128, offset 0, 4 beats, byteen 0xF each, last on beat 4 → one word, o_byteen 0xFFFF, o_last 1, latency 1 cycle.
- Offset 2, 3 beats D0..D2 → word 1 has lanes 2,3 = D0,D1, byteen 0xFF00, o_last 0. Word 2 has lane 0 = D2, byteen 0x000F, o_last 1.
- Offset 1, single beat with last, byteen 0x3 → o_byteen 0x0030, o_last 1, data zero outside bits [47:32].
- Bypass = 1, offset 3, 3 beats → three words, each on lane 0, byteen 0x000F, last only on the third.
- Hold i_ready = 0 with o_valid high for 5 cycles, then stream 8 beats → o_ready 0 throughout the stall, o_data stable, no beat lost, 2 words out.
- Assert i_clear after 2 of 4 beats → o_valid 0 next cycle, o_busy 0. A fresh burst with offset 0 produces a clean word with no stale lanes.
